// File: rtl/fmul_sched.sv
`default_nettype none
// ============================================================================
// Module   : fmul_sched
// Purpose  : Round-robin scheduler sharing one pipelined multiplier among
//            NREQ requesters, holding each product until its requester accepts.
// Revision : 1.0 - initial release
// ============================================================================
module fmul_sched #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   rsp_vld,
    input  logic [NREQ-1:0]   rsp_rdy,
    output logic [NREQ*N-1:0] rsp_data,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    output logic              mul_go,
    input  logic [N-1:0]      mul_res,
    output logic              busy,
    output logic [15:0]       op_cnt
);
    localparam int c_tag_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    r_outstanding;
    logic [NREQ-1:0]    r_rsp_vld;
    logic [N-1:0]       r_rsp_data [NREQ];
    logic [c_tag_w-1:0] r_last_grant;
    logic [c_tag_w-1:0] r_go_tag;
    logic               r_mul_go;
    logic [N-1:0]       r_mul_a;
    logic [N-1:0]       r_mul_b;
    logic [LAT-1:0]     r_pipe_vld;
    logic [c_tag_w-1:0] r_pipe_tag [LAT];
    logic [15:0]        r_op_cnt;

    logic [NREQ-1:0]    w_eligible;
    logic [NREQ-1:0]    w_req_hs;
    logic [NREQ-1:0]    w_rsp_hs;
    logic               w_grant_any;
    logic [c_tag_w-1:0] w_grant_idx;
    logic [c_tag_w-1:0] w_cand;
    logic [15:0]        w_rsp_cnt;

    // Outstanding still set during the response handshake, so a requester
    // completing this cycle cannot be re-granted until the next one.
    assign w_eligible = req_vld & ~r_outstanding;
    assign w_rsp_hs   = r_rsp_vld & rsp_rdy;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_tag_w'((int'(r_last_grant) + k) % NREQ);
            if (!w_grant_any && w_eligible[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_req_hs = '0;
        if (rst && w_grant_any) begin
            w_req_hs[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_rsp_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_cnt = w_rsp_cnt + {15'd0, w_rsp_hs[i]};
        end
    end

    // The tag registered with mul_go acts as the entry point of the tag pipe,
    // so its last stage lines up with mul_res LAT cycles after mul_go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_rsp_vld     <= '0;
            r_last_grant  <= c_tag_w'(NREQ - 1);
            r_go_tag      <= '0;
            r_mul_go      <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_pipe_vld    <= '0;
            r_op_cnt      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_data[i] <= '0;
            end
            for (int s = 0; s < LAT; s++) begin
                r_pipe_tag[s] <= '0;
            end
        end else begin
            r_mul_go <= w_req_hs[w_grant_idx];
            if (w_req_hs[w_grant_idx]) begin
                r_mul_a      <= req_a[w_grant_idx*N +: N];
                r_mul_b      <= req_b[w_grant_idx*N +: N];
                r_go_tag     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end

            r_pipe_vld[0] <= r_mul_go;
            r_pipe_tag[0] <= r_go_tag;
            for (int s = 1; s < LAT; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_tag[s] <= r_pipe_tag[s-1];
            end

            for (int i = 0; i < NREQ; i++) begin
                if (w_req_hs[i]) begin
                    r_outstanding[i] <= 1'b1;
                end else if (w_rsp_hs[i]) begin
                    r_outstanding[i] <= 1'b0;
                end
                if (w_rsp_hs[i]) begin
                    r_rsp_vld[i] <= 1'b0;
                end
                if (r_pipe_vld[LAT-1] && (r_pipe_tag[LAT-1] == c_tag_w'(i))) begin
                    r_rsp_vld[i]  <= 1'b1;
                    r_rsp_data[i] <= mul_res;
                end
            end

            r_op_cnt <= r_op_cnt + w_rsp_cnt;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp_pack
        assign rsp_data[gi*N +: N] = r_rsp_data[gi];
    end

    assign req_rdy = w_req_hs;
    assign rsp_vld = r_rsp_vld;
    assign mul_a   = r_mul_a;
    assign mul_b   = r_mul_b;
    assign mul_go  = r_mul_go;
    assign busy    = |r_outstanding;
    assign op_cnt  = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fmul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_sched
// Purpose  : Self-checking bench for fmul_sched against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_sched;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [NREQ*N-1:0] req_a, req_b, rsp_data;
    logic [N-1:0]      mul_a, mul_b, mul_res;
    logic              mul_go, busy;
    logic [15:0]       op_cnt;

    logic [NREQ-1:0]   s1_req_vld, s1_req_rdy, s1_rsp_vld, s1_rsp_rdy;
    logic [NREQ*N-1:0] s1_req_a, s1_req_b, s1_rsp_data;
    logic [N-1:0]      s1_mul_a, s1_mul_b, s1_mul_res;
    logic              s1_mul_go, s1_busy;
    logic [15:0]       s1_op_cnt;

    logic [NREQ-1:0]   s8_req_vld, s8_req_rdy, s8_rsp_vld, s8_rsp_rdy;
    logic [NREQ*N-1:0] s8_req_a, s8_req_b, s8_rsp_data;
    logic [N-1:0]      s8_mul_a, s8_mul_b, s8_mul_res;
    logic              s8_mul_go, s8_busy;
    logic [15:0]       s8_op_cnt;

    fmul_sched #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_go(mul_go),
        .mul_res(mul_res), .busy(busy), .op_cnt(op_cnt)
    );

    fmul_sched #(.N(N), .NREQ(NREQ), .LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_vld(s1_req_vld), .req_rdy(s1_req_rdy),
        .req_a(s1_req_a), .req_b(s1_req_b), .rsp_vld(s1_rsp_vld), .rsp_rdy(s1_rsp_rdy),
        .rsp_data(s1_rsp_data), .mul_a(s1_mul_a), .mul_b(s1_mul_b), .mul_go(s1_mul_go),
        .mul_res(s1_mul_res), .busy(s1_busy), .op_cnt(s1_op_cnt)
    );

    fmul_sched #(.N(N), .NREQ(NREQ), .LAT(8)) dut_l8 (
        .clk(clk), .rst(rst), .req_vld(s8_req_vld), .req_rdy(s8_req_rdy),
        .req_a(s8_req_a), .req_b(s8_req_b), .rsp_vld(s8_rsp_vld), .rsp_rdy(s8_rsp_rdy),
        .rsp_data(s8_rsp_data), .mul_a(s8_mul_a), .mul_b(s8_mul_b), .mul_go(s8_mul_go),
        .mul_res(s8_mul_res), .busy(s8_busy), .op_cnt(s8_op_cnt)
    );

    // Normal-number fp32 multiply (truncating), standing in for the external unit.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // External multipliers: product appears exactly LAT cycles after mul_go, garbage otherwise.
    logic [N-1:0] mp2 [2];
    logic [N-1:0] mp1 [1];
    logic [N-1:0] mp8 [8];
    always @(posedge clk) begin
        mp2[0] <= mul_go ? fp_mul(mul_a, mul_b) : 32'hDEADBEEF;
        mp2[1] <= mp2[0];
        mp1[0] <= s1_mul_go ? fp_mul(s1_mul_a, s1_mul_b) : 32'hDEADBEEF;
        mp8[0] <= s8_mul_go ? fp_mul(s8_mul_a, s8_mul_b) : 32'hDEADBEEF;
        for (int k = 1; k < 8; k++) mp8[k] <= mp8[k-1];
    end
    assign mul_res    = mp2[1];
    assign s1_mul_res = mp1[0];
    assign s8_mul_res = mp8[7];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int           tag;
        logic [N-1:0] prod;
        int           due;
    } fl_t;

    fl_t             fl[$];
    logic [NREQ-1:0] m_out, m_rv;
    logic [N-1:0]    m_rd [NREQ];
    int              m_last, m_issued, cyc;
    logic [15:0]     m_cnt;
    logic            m_go;
    logic [N-1:0]    m_a, m_b;

    initial begin
        cyc = 0;
        m_issued = 0;
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        cyc++;
        if (!rst) begin
            m_out = '0; m_rv = '0; m_last = NREQ - 1; m_cnt = '0;
            m_go = 1'b0; m_a = '0; m_b = '0; m_issued = 0;
            fl.delete();
            for (int i = 0; i < NREQ; i++) m_rd[i] = '0;
        end
        for (int q = fl.size() - 1; q >= 0; q--) begin
            if (fl[q].due == cyc) begin
                m_rv[fl[q].tag] = 1'b1;
                m_rd[fl[q].tag] = fl[q].prod;
                fl.delete(q);
            end
        end
        g = -1;
        exp_rdy = '0;
        if (rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_vld[(m_last + k) % NREQ] && !m_out[(m_last + k) % NREQ])
                    g = (m_last + k) % NREQ;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        check("m_req_rdy", req_rdy, exp_rdy);
        check("m_mul_go", mul_go, m_go);
        check("m_mul_a", mul_a, m_a);
        check("m_mul_b", mul_b, m_b);
        check("m_rsp_vld", rsp_vld, m_rv);
        for (int i = 0; i < NREQ; i++) check("m_rsp_data", rsp_data[i*N +: N], m_rd[i]);
        check("m_busy", busy, |m_out);
        check("m_op_cnt", op_cnt, m_cnt);

        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_rv[i] && rsp_rdy[i]) begin
                    m_rv[i] = 1'b0;
                    m_out[i] = 1'b0;
                    m_cnt = m_cnt + 16'd1;
                end
            end
            m_go = (g >= 0);
            if (g >= 0) begin
                m_out[g] = 1'b1;
                m_last = g;
                m_a = req_a[g*N +: N];
                m_b = req_b[g*N +: N];
                fl.push_back('{tag: g, prod: fp_mul(m_a, m_b), due: cyc + LAT + 2});
                m_issued++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b0; req_vld = '0; rsp_rdy = '0;
        tick();
        rst = 1'b1;
    endtask

    task automatic lat_probe(input int sel, output int lat, output logic [31:0] data);
        int t_go, t_rsp;
        t_go = -1; t_rsp = -1;
        tick();
        if (sel == 1) s1_req_vld = 4'b0001; else s8_req_vld = 4'b0001;
        tick();
        s1_req_vld = '0; s8_req_vld = '0;
        for (int c = 0; c < 20 && t_rsp < 0; c++) begin
            @(negedge clk);
            if (t_go < 0 && (sel == 1 ? s1_mul_go : s8_mul_go)) t_go = c;
            if (sel == 1 ? s1_rsp_vld[0] : s8_rsp_vld[0]) t_rsp = c;
        end
        lat  = (t_go >= 0 && t_rsp >= 0) ? t_rsp - t_go : -1;
        data = (sel == 1) ? s1_rsp_data[31:0] : s8_rsp_data[31:0];
    endtask

    initial begin
        int   grants1, lat;
        logic found;
        logic [31:0] d;
        req_vld = '0; rsp_rdy = '0; req_a = '0; req_b = '0;
        s1_req_vld = '0; s1_rsp_rdy = '0; s1_req_a = '0; s1_req_b = '0;
        s8_req_vld = '0; s8_rsp_rdy = '0; s8_req_a = '0; s8_req_b = '0;
        repeat (3) tick();
        check("reset_rdy", req_rdy, 4'b0000);
        check("reset_busy", busy, 1'b0);
        rst = 1'b1;

        // single op: 2.0 * 3.0
        req_a[31:0] = 32'h40000000; req_b[31:0] = 32'h40400000;
        tick();
        req_vld = 4'b0001;
        @(negedge clk); check("single_rdy", req_rdy, 4'b0001);
        tick();
        req_vld = '0;
        @(negedge clk); check("single_go", mul_go, 1'b1);
        repeat (2) begin @(negedge clk); check("single_rsp_early", rsp_vld[0], 1'b0); end
        @(negedge clk);
        check("single_rsp_vld", rsp_vld[0], 1'b1);
        check("single_data", rsp_data[31:0], 32'h40C00000);
        tick(); rsp_rdy[0] = 1'b1;
        tick(); rsp_rdy[0] = 1'b0;
        @(negedge clk); check("single_op_cnt", op_cnt, 16'd1);

        // all four requesters, responses always accepted
        reset_dut();
        req_a = {32'h3FC00000, 32'h3F800000, 32'h40400000, 32'h40000000};
        req_b = {32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000};
        req_vld = 4'hF; rsp_rdy = 4'hF;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("rr_grant", req_rdy, (j < 4) ? (4'b0001 << j) : 4'b0000);
            if (j >= 1) check("rr_mul_go", mul_go, 1'b1);
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (rsp_vld[2]) begin
                found = 1'b1;
                check("rr_data2", rsp_data[95:64], 32'h3F800000);
            end
        end
        check("rr_rsp2_seen", found, 1'b1);
        repeat (8) tick();
        req_vld = '0;
        repeat (8) tick();

        // requester 1 stalls its response
        reset_dut();
        rsp_rdy = 4'b1101; req_vld = 4'hF;
        grants1 = 0;
        repeat (20) begin @(negedge clk); if (req_rdy[1]) grants1++; end
        check("stall_grants1", grants1, 1);
        check("stall_vld1", rsp_vld[1], 1'b1);
        check("stall_data1", rsp_data[63:32], 32'h40C00000);
        tick(); rsp_rdy[1] = 1'b1;
        repeat (10) tick();
        req_vld = '0;
        repeat (8) tick();

        // fill every requester, then accept all four in one cycle
        rsp_rdy = '0; req_vld = 4'hF;
        repeat (6) tick();
        req_vld = '0;
        repeat (6) tick();
        check("fill_all_vld", rsp_vld, 4'hF);
        rsp_rdy = 4'hF;
        tick();
        rsp_rdy = '0;
        repeat (2) tick();

        // reset one cycle after issue discards the op
        tick(); req_vld = 4'b0001;
        tick(); req_vld = '0;
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        repeat (6) begin @(negedge clk); check("rst_no_rsp", rsp_vld, 4'b0000); end
        tick(); req_vld = 4'hF;
        @(negedge clk); check("rst_first_grant", req_rdy, 4'b0001);
        tick(); req_vld = '0;
        repeat (8) tick();

        // op_cnt wrap
        reset_dut();
        req_vld = 4'hF; rsp_rdy = 4'hF;
        found = 1'b0;
        for (int c = 0; c < 90000 && !found; c++) begin
            tick();
            if (m_issued >= 65535) begin
                req_vld = '0;
                found = 1'b1;
            end
        end
        check("wrap_fill_done", found, 1'b1);
        repeat (10) tick();
        check("wrap_ffff", op_cnt, 16'hFFFF);
        req_vld = 4'b0001;
        tick(); req_vld = '0;
        repeat (8) tick();
        check("wrap_zero", op_cnt, 16'h0000);
        rsp_rdy = '0;

        // latency of LAT=1 and LAT=8 builds
        s1_req_a[31:0] = 32'h40000000; s1_req_b[31:0] = 32'h40400000;
        s8_req_a[31:0] = 32'h40000000; s8_req_b[31:0] = 32'h40400000;
        lat_probe(1, lat, d);
        check("lat1", lat, 2);
        check("lat1_data", d, 32'h40C00000);
        lat_probe(8, lat, d);
        check("lat8", lat, 9);
        check("lat8_data", d, 32'h40C00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
